// File: rtl/kb_scan_sequencer.sv
// PS/2 keyboard receive sequencer: frame deserializer, make/break/E0
// protocol tracker and a small event FIFO with valid/ready handshake.
module kb_scan_sequencer #(
  parameter int TIMEOUT_CYC = 2000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       CLK,
  input  logic       ARST_L,
  input  logic       SCLK_S,
  input  logic       SDATA_S,
  input  logic       EVT_READY,
  output logic       EVT_VALID,
  output logic [7:0] EVT_CODE,
  output logic       EVT_EXT,
  output logic       EVT_BREAK,
  output logic       FRAME_ERR,
  output logic [7:0] ERR_CNT,
  output logic       FIFO_OVF
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    F_IDLE, F_DATA, F_PAR, F_STOP
  } fst_t;

  // bit0 = E0 seen, bit1 = F0 seen
  typedef enum logic [1:0] {
    C_NORM   = 2'b00,
    C_EXT    = 2'b01,
    C_BRK    = 2'b10,
    C_EXTBRK = 2'b11
  } cst_t;

  fst_t          r_fst, w_fst_nx;
  cst_t          r_cst, w_cst_nx;
  logic          r_prev_sclk;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_tcnt;
  logic          r_byte_ok;
  logic [7:0]    r_byte;
  logic          r_frame_err;
  logic [7:0]    r_err_cnt;
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;

  logic       w_fall, w_tout, w_ok, w_bad;
  logic       w_emit, w_drop;
  logic       w_is_e0, w_is_f0, w_is_nul;
  logic       w_pop, w_full, w_push;
  logic [8:0] w_err_sum;
  logic [9:0] w_head;

  assign w_fall = r_prev_sclk & ~SCLK_S;
  assign w_tout = (r_fst != F_IDLE) && !w_fall &&
                  (r_tcnt == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    w_fst_nx = r_fst;
    w_ok     = 1'b0;
    w_bad    = 1'b0;
    if (w_tout) begin
      w_fst_nx = F_IDLE;
      w_bad    = 1'b1;
    end else if (w_fall) begin
      unique case (r_fst)
        F_IDLE: if (!SDATA_S) w_fst_nx = F_DATA;
        F_DATA: if (r_bitcnt == 3'd7) w_fst_nx = F_PAR;
        F_PAR:  w_fst_nx = F_STOP;
        F_STOP: begin
          w_fst_nx = F_IDLE;
          if (SDATA_S && (^{r_shift, r_par})) w_ok = 1'b1;
          else w_bad = 1'b1;
        end
        default: w_fst_nx = F_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      r_fst       <= F_IDLE;
      r_prev_sclk <= 1'b1;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_tcnt      <= '0;
      r_byte_ok   <= 1'b0;
      r_byte      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_fst       <= w_fst_nx;
      r_prev_sclk <= SCLK_S;
      r_byte_ok   <= w_ok;
      r_frame_err <= w_bad;
      if (w_ok) r_byte <= r_shift;
      if (w_fall || r_fst == F_IDLE) r_tcnt <= '0;
      else r_tcnt <= r_tcnt + 1'b1;
      if (w_fall && r_fst == F_IDLE) r_bitcnt <= '0;
      if (w_fall && r_fst == F_DATA) begin
        r_shift  <= {SDATA_S, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_fall && r_fst == F_PAR) r_par <= SDATA_S;
    end
  end

  assign w_is_e0  = (r_byte == 8'hE0);
  assign w_is_f0  = (r_byte == 8'hF0);
  assign w_is_nul = (r_byte == 8'h00) || (r_byte == 8'hFF);

  always_comb begin
    w_cst_nx = r_cst;
    w_emit   = 1'b0;
    w_drop   = 1'b0;
    if (r_frame_err) begin
      w_cst_nx = C_NORM;
    end else if (r_byte_ok) begin
      unique case (1'b1)
        w_is_e0: w_cst_nx = cst_t'({r_cst[1], 1'b1});
        w_is_f0: w_cst_nx = cst_t'({1'b1, r_cst[0]});
        default: begin
          w_cst_nx = C_NORM;
          if (r_cst == C_NORM && w_is_nul) w_drop = 1'b1;
          else w_emit = 1'b1;
        end
      endcase
    end
  end

  // A frame abort and a dropped byte never share a cycle, but sum anyway
  assign w_err_sum = {1'b0, r_err_cnt} + 9'(w_bad) + 9'(w_drop);

  assign w_full = (r_cnt == CW'(FIFO_DEPTH));
  assign w_pop  = (r_cnt != '0) && EVT_READY;
  assign w_push = w_emit && (!w_full || w_pop);

  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      r_cst     <= C_NORM;
      r_err_cnt <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_cst     <= w_cst_nx;
      r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      if (w_push) begin
        r_mem[r_wp] <= {r_cst[1], r_cst[0], r_byte};
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (w_emit && !w_push) r_ovf <= 1'b1;
    end
  end

  assign w_head    = r_mem[r_rp];
  assign EVT_VALID = (r_cnt != '0);
  assign EVT_CODE  = w_head[7:0];
  assign EVT_EXT   = w_head[8];
  assign EVT_BREAK = w_head[9];
  assign FRAME_ERR = r_frame_err;
  assign ERR_CNT   = r_err_cnt;
  assign FIFO_OVF  = r_ovf;

endmodule

// File: doc/kb_scan_sequencer.md
Name: kb_scan_sequencer

Overview:
Sequences the PS/2 keyboard receive path in the CLK domain. It deserializes 11-bit frames from the already-synchronized keyboard clock and data, checks framing and parity, and tracks the multi-byte make/break/extended protocol (E0, F0 prefixes). Completed key events go into a small FIFO with a valid/ready handshake toward the display and strobe logic. It replaces ad-hoc F0 detection with a protocol-aware controller that includes error recovery.

Parameters:
TIMEOUT_CYC, 2000, max CLK cycles between keyboard-clock falling edges inside a frame before abort (2 ms at 1 MHz)
FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)

Ports:
CLK  in  1  system clock (fast divided clock)
ARST_L  in  1  async active-low reset
SCLK_S  in  1  synchronized keyboard clock
SDATA_S  in  1  synchronized keyboard data
EVT_READY  in  1  consumer accepts head event
EVT_VALID  out  1  FIFO non-empty
EVT_CODE  out  8  head event scan code
EVT_EXT  out  1  head event was E0-prefixed
EVT_BREAK  out  1  head event was F0-prefixed (key release)
FRAME_ERR  out  1  one-cycle pulse on any frame abort
ERR_CNT  out  8  saturating error count
FIFO_OVF  out  1  sticky, event dropped because FIFO was full

Behaviour:
- Reset (async, ARST_L=0): all outputs 0; frame FSM IDLE; code FSM NORM; FIFO empty; edge register = 1. Reset mid-frame discards the partial frame with no pulse.
- Edge detect: fall = prev_SCLK_S & ~SCLK_S. SDATA_S is sampled in the same cycle as fall.
- Frame FSM:
  - IDLE: fall with data=0 -> DATA, bitcnt=0. Fall with data=1 -> stay, no error.
  - DATA: shift in LSB first. After the 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: on fall, byte ok iff data=1 and XOR(8 data, parity)=1. Otherwise FRAME_ERR. Return to IDLE either way.
- Timeout: counter clears on every fall and while IDLE. In any other state, count==TIMEOUT_CYC-1 -> IDLE, FRAME_ERR.
- Errors: FRAME_ERR pulses the cycle after detection. ERR_CNT increments once per error and saturates at 255. Any frame error forces the code FSM to NORM.
- Byte strobe: byte_ok asserts 1 cycle after the STOP fall.
- Code FSM, on byte_ok:
  - NORM: E0->EXT; F0->BRK; 00/FF -> drop, ERR_CNT++; other -> emit(ext=0, brk=0).
  - EXT: F0->EXTBRK; E0->stay; other -> emit(1,0), NORM.
  - BRK: F0->stay; E0->EXTBRK; other -> emit(0,1), NORM.
  - EXTBRK: E0/F0 -> stay; other -> emit(1,1), NORM.
- Emit: pushes {brk, ext, code} in the same cycle as byte_ok. EVT_* is visible 1 cycle later (first-word fall-through, registered).
- Total latency: STOP fall at cycle N -> EVT_VALID=1 at N+2 when the FIFO was empty.
- Handshake:
  - Pop when EVT_VALID & EVT_READY. The next entry appears on the following cycle.
  - EVT_CODE/EXT/BREAK stay stable while VALID=1 and READY=0.
- FIFO boundaries:
  - Push with pop in the same cycle when full is accepted; count is unchanged.
  - Push when full with no pop drops the event and sets FIFO_OVF, which stays set until reset.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Frame 1C (start 0, data LSB first, parity 0, stop 1), READY=1 -> EVT_VALID pulses 1 cycle at N+2 with CODE=1C, EXT=0, BREAK=0.
- Sequence F0,1C -> one event CODE=1C, BREAK=1, EXT=0. Sequence E0,F0,75 -> CODE=75, EXT=1, BREAK=1. No event is emitted for the prefix bytes.
- Frame 1C with parity flipped -> FRAME_ERR pulse, ERR_CNT=1, no event. Then F0 with bad stop followed by 1C -> event 1C with BREAK=0 (code FSM was reset).
- Stop the clock after 4 data bits for TIMEOUT_CYC cycles -> FRAME_ERR, FSM IDLE. The next good frame 2A decodes correctly.
- READY=0, send 5 make codes 15,16,1E,26,25 with DEPTH=4 -> FIFO_OVF=1. Then READY=1 pops 15,16,1E,26 in order and VALID drops after the 4th.
- Assert ARST_L=0 after 5 data bits with 2 events queued -> all outputs 0 immediately. After release, frame 1C decodes normally.
